// File: rtl/hwpe_stream_package.sv
// Shared types for the HWPE sink-side stream packer.
// Contents:
//   PACKER_CNT_WIDTH - width of the word counter, nb_words and beat_cnt
//   ctrl_packer_t    - req_start, nb_words
//   flags_packer_t   - ready_start, done, beat_cnt
//   state_packer_t   - packer FSM states
package hwpe_stream_package;

  localparam int unsigned PACKER_CNT_WIDTH = 16;

  typedef struct packed {
    logic                        req_start;
    logic [PACKER_CNT_WIDTH-1:0] nb_words;
  } ctrl_packer_t;

  typedef struct packed {
    logic                        ready_start;
    logic                        done;
    logic [PACKER_CNT_WIDTH-1:0] beat_cnt;
  } flags_packer_t;

  typedef enum logic [1:0] {
    PACKER_IDLE,
    PACKER_PACK,
    PACKER_DRAIN,
    PACKER_DONE
  } state_packer_t;

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Valid/ready stream with byte strobes.
// Signals:
//   valid - producer has a word
//   ready - consumer accepts the word this cycle
//   data  - DATA_WIDTH payload
//   strb  - one bit per payload byte
// Modports: source (producer side), sink (consumer side).
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport source (output valid, output data, output strb, input ready);
  modport sink   (input valid, input data, input strb, output ready);

endinterface

// File: rtl/hwpe_stream_sink_packer.sv
// Packs a narrow engine stream (IN_WIDTH) into full-width beats (IN_WIDTH*RATIO)
// for the HWPE sink. A short tail beat keeps its unused lanes at data 0, strb 0.
// Ports:
//   clk_i, rst_ni - clock, asynchronous active-low reset
//   clear_i       - synchronous clear, same effect as reset
//   push_i        - narrow input stream (sink side)
//   pop_o         - wide output stream (source side), single-entry out register
//   ctrl_i        - req_start, nb_words
//   flags_o       - ready_start, done (one-cycle pulse), beat_cnt
module hwpe_stream_sink_packer
  import hwpe_stream_package::*;
#(
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned RATIO     = 4,
  // must match PACKER_CNT_WIDTH, which sizes the ctrl/flags structs
  parameter int unsigned CNT_WIDTH = PACKER_CNT_WIDTH
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clear_i,
  hwpe_stream_intf_stream.sink          push_i,
  hwpe_stream_intf_stream.source        pop_o,
  input  ctrl_packer_t                  ctrl_i,
  output flags_packer_t                 flags_o
);

  localparam int unsigned OUT_WIDTH = IN_WIDTH * RATIO;
  localparam int unsigned IN_STRB   = IN_WIDTH / 8;
  localparam int unsigned OUT_STRB  = OUT_WIDTH / 8;
  localparam int unsigned LANE_W    = $clog2(RATIO);

  state_packer_t          state_q;
  logic [OUT_WIDTH-1:0]   buf_data_q;
  logic [OUT_STRB-1:0]    buf_strb_q;
  logic [LANE_W-1:0]      lane_q;
  logic [CNT_WIDTH-1:0]   words_left_q;
  logic                   out_valid_q;
  logic [OUT_WIDTH-1:0]   out_data_q;
  logic [OUT_STRB-1:0]    out_strb_q;
  logic [CNT_WIDTH-1:0]   beat_cnt_q;

  logic                   in_pack;
  logic                   closing;
  logic                   tail_pending;
  logic                   push_hs;
  logic                   pop_hs;
  logic [OUT_WIDTH-1:0]   merged_data;
  logic [OUT_STRB-1:0]    merged_strb;

  // A word closes the beat when it fills the last lane or is the last word.
  assign in_pack      = (state_q == PACKER_PACK);
  assign closing      = (lane_q == LANE_W'(RATIO - 1)) || (words_left_q == CNT_WIDTH'(1));
  // Closing word has nowhere to go: out register full and not leaving this cycle.
  assign tail_pending = in_pack && closing && out_valid_q && !pop_o.ready;

  assign push_i.ready = in_pack && !tail_pending;
  assign push_hs      = push_i.valid && push_i.ready;
  assign pop_hs       = out_valid_q && pop_o.ready;

  assign pop_o.valid  = out_valid_q;
  assign pop_o.data   = out_data_q;
  assign pop_o.strb   = out_strb_q;

  assign flags_o = '{ready_start: (state_q == PACKER_IDLE),
                     done:        (state_q == PACKER_DONE),
                     beat_cnt:    PACKER_CNT_WIDTH'(beat_cnt_q)};

  // Buffer contents with the incoming word dropped into the current lane;
  // lets a closing word go straight to the out register without a bubble.
  always_comb begin
    merged_data = buf_data_q;
    merged_strb = buf_strb_q;
    merged_data[lane_q*IN_WIDTH +: IN_WIDTH] = push_i.data;
    merged_strb[lane_q*IN_STRB +: IN_STRB]   = push_i.strb;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= PACKER_IDLE;
      buf_data_q   <= '0;
      buf_strb_q   <= '0;
      lane_q       <= '0;
      words_left_q <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_strb_q   <= '0;
      beat_cnt_q   <= '0;
    end else if (clear_i) begin
      state_q      <= PACKER_IDLE;
      buf_data_q   <= '0;
      buf_strb_q   <= '0;
      lane_q       <= '0;
      words_left_q <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_strb_q   <= '0;
      beat_cnt_q   <= '0;
    end else begin
      // A closing load later in this block overrides the clear of valid,
      // so a pop and a new beat can share one cycle.
      if (pop_hs) begin
        out_valid_q <= 1'b0;
        beat_cnt_q  <= beat_cnt_q + CNT_WIDTH'(1);
      end
      unique case (state_q)
        PACKER_IDLE: begin
          if (ctrl_i.req_start) begin
            words_left_q <= CNT_WIDTH'(ctrl_i.nb_words);
            lane_q       <= '0;
            buf_data_q   <= '0;
            buf_strb_q   <= '0;
            beat_cnt_q   <= '0;
            state_q      <= (ctrl_i.nb_words == '0) ? PACKER_DONE : PACKER_PACK;
          end
        end
        PACKER_PACK: begin
          if (push_hs) begin
            words_left_q <= words_left_q - CNT_WIDTH'(1);
            if (closing) begin
              out_valid_q <= 1'b1;
              out_data_q  <= merged_data;
              out_strb_q  <= merged_strb;
              buf_data_q  <= '0;
              buf_strb_q  <= '0;
              lane_q      <= '0;
            end else begin
              buf_data_q  <= merged_data;
              buf_strb_q  <= merged_strb;
              lane_q      <= lane_q + LANE_W'(1);
            end
            if (words_left_q == CNT_WIDTH'(1)) state_q <= PACKER_DRAIN;
          end
        end
        PACKER_DRAIN: begin
          if (!out_valid_q || pop_hs) state_q <= PACKER_DONE;
        end
        PACKER_DONE: state_q <= PACKER_IDLE;
        default:     state_q <= PACKER_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hwpe_stream_sink_packer.sv
module tb_hwpe_stream_sink_packer;
  import hwpe_stream_package::*;

  localparam int IW = 32;
  localparam int R  = 4;
  localparam int OW = IW * R;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  always #5 clk = ~clk;

  hwpe_stream_intf_stream #(.DATA_WIDTH(IW)) push ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(OW)) pop ();
  ctrl_packer_t  ctrl;
  flags_packer_t flags;

  hwpe_stream_sink_packer #(.IN_WIDTH(IW), .RATIO(R), .CNT_WIDTH(16)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clear_i (clear),
    .push_i  (push),
    .pop_o   (pop),
    .ctrl_i  (ctrl),
    .flags_o (flags)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_busy = 0;
  bit          m_done_now = 0;
  int          m_nb = 0;
  int          m_acc = 0;
  int          m_pops = 0;
  logic [31:0] m_words[$];
  logic [3:0]  m_strbs[$];
  bit          m_prev_stall = 0;
  logic [OW-1:0]   m_prev_data;
  logic [OW/8-1:0] m_prev_strb;

  int cyc = 0;
  int done_cnt = 0, start_cnt = 0;
  int t_start_cyc, t_done_cyc, t_done_beats, t_push_first, t_push_last;
  int t_pop_valid_cyc, t_stall_acc, t_stall_wait;
  logic [OW-1:0]   log_data[$];
  logic [OW/8-1:0] log_strb[$];
  int              t_pop_cyc[$];

  function automatic int beats_total(input int nb);
    return (nb + R - 1) / R;
  endfunction

  // Beats whose words have all been accepted: full groups, plus the tail once the count is reached.
  function automatic int beats_formed();
    return (m_acc == m_nb) ? beats_total(m_nb) : m_acc / R;
  endfunction

  function automatic logic [OW-1:0] exp_data(input int k);
    logic [OW-1:0] d = '0;
    for (int l = 0; l < R; l++)
      if (k*R + l < m_nb && k*R + l < m_words.size()) d[l*IW +: IW] = m_words[k*R + l];
    return d;
  endfunction

  function automatic logic [OW/8-1:0] exp_strb(input int k);
    logic [OW/8-1:0] s = '0;
    for (int l = 0; l < R; l++)
      if (k*R + l < m_nb && k*R + l < m_strbs.size()) s[l*4 +: 4] = m_strbs[k*R + l];
    return s;
  endfunction

  always @(negedge clk) begin : mon
    int  avail;
    bit  active, closing, nd, push_hs, pop_hs;
    if (rst_n) begin
      cyc++;
      avail  = beats_formed() - m_pops;
      active = m_busy && (m_acc < m_nb) && !m_done_now;
      chk("ready_start", 128'(flags.ready_start), 128'(!m_busy));
      chk("done", 128'(flags.done), 128'(m_done_now));
      chk("beat_cnt", 128'(flags.beat_cnt), 128'(m_pops[15:0]));
      chk("pop_valid", 128'(pop.valid), 128'(avail > 0));
      if (m_prev_stall) begin
        chk("hold_data", 128'(pop.data), 128'(m_prev_data));
        chk("hold_strb", 128'(pop.strb), 128'(m_prev_strb));
      end
      if (!active) chk("push_ready_idle", 128'(push.ready), 128'(0));
      else begin
        closing = ((m_acc % R) == R - 1) || (m_nb - m_acc == 1);
        chk("push_ready", 128'(push.ready), 128'(!closing || avail == 0 || pop.ready));
      end
      push_hs = push.valid && push.ready && active;
      pop_hs  = pop.valid && pop.ready && avail > 0;
      if (pop_hs) begin
        chk("beat_data", 128'(pop.data), 128'(exp_data(m_pops)));
        chk("beat_strb", 128'(pop.strb), 128'(exp_strb(m_pops)));
      end

      if (clear) begin
        m_busy = 0; m_done_now = 0; m_nb = 0; m_acc = 0; m_pops = 0;
        m_words.delete(); m_strbs.delete();
      end else begin
        nd = 0;
        if (ctrl.req_start && !m_busy) begin
          m_busy = 1; m_nb = int'(ctrl.nb_words); m_acc = 0; m_pops = 0;
          m_words.delete(); m_strbs.delete();
          start_cnt++; t_start_cyc = cyc;
          t_push_first = -1; t_push_last = -1; t_pop_valid_cyc = 0;
          t_stall_acc = 0; t_stall_wait = 0;
          log_data.delete(); log_strb.delete(); t_pop_cyc.delete();
          if (m_nb == 0) nd = 1;
        end
        if (m_done_now) m_busy = 0;
        if (pop.valid) t_pop_valid_cyc++;
        if (push_hs) begin
          m_words.push_back(push.data);
          m_strbs.push_back(push.strb);
          m_acc++;
          if (t_push_first < 0) t_push_first = cyc;
          t_push_last = cyc;
          if (pop.valid && !pop.ready) t_stall_acc++;
        end
        if (push.valid && !push.ready && pop.valid && !pop.ready) t_stall_wait++;
        if (pop_hs) begin
          log_data.push_back(pop.data);
          log_strb.push_back(pop.strb);
          t_pop_cyc.push_back(cyc);
          m_pops++;
          if (m_acc == m_nb && m_pops == beats_total(m_nb)) nd = 1;
        end
        if (flags.done) begin
          done_cnt++; t_done_cyc = cyc; t_done_beats = int'(flags.beat_cnt);
        end
        m_done_now = nd;
      end
      m_prev_stall = pop.valid && !pop.ready && !clear;
      m_prev_data  = pop.data;
      m_prev_strb  = pop.strb;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle();
    int n = 0;
    while (flags.ready_start !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) begin
      total++; bad++;
      $display("FAIL idle_timeout: ready_start=%b want 1", flags.ready_start);
    end
  endtask

  task automatic run_xfer(input int nb, input logic [31:0] base, input bit rnd,
                          input int stall_len, input int clear_after);
    int i = 0, n = 0, d0, stall_ctr = 0;
    bit hs;
    wait_idle();
    d0 = done_cnt;
    ctrl.req_start = 1'b1;
    ctrl.nb_words  = nb[15:0];
    @(posedge clk); #1;
    ctrl.req_start = 1'b0;
    while (done_cnt == d0 && n < 3000) begin
      if (clear_after > 0 && i == clear_after) begin
        push.valid = 1'b0;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        break;
      end
      push.valid = (i < nb) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
      push.data  = base + 32'(i);
      push.strb  = rnd ? 4'($urandom) : 4'hF;
      if (rnd) pop.ready = ($urandom_range(0, 1) == 1);
      else if (stall_len > 0 && stall_ctr < stall_len && (stall_ctr > 0 || pop.valid)) begin
        pop.ready = 1'b0; stall_ctr++;
      end else pop.ready = 1'b1;
      @(negedge clk);
      hs = push.valid && push.ready;
      @(posedge clk); #1;
      if (hs) i++;
      n++;
    end
    push.valid = 1'b0;
    pop.ready  = 1'b1;
    if (n >= 3000) begin
      total++; bad++;
      $display("FAIL xfer_timeout: nb=%0d accepted=%0d", nb, i);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    push.valid = 1'b0; push.data = '0; push.strb = '0;
    pop.ready  = 1'b1;
    ctrl       = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pop_valid", 128'(pop.valid), 128'(0));
    chk("rst_pop_data", 128'(pop.data), 128'(0));
    chk("rst_pop_strb", 128'(pop.strb), 128'(0));
    chk("rst_push_ready", 128'(push.ready), 128'(0));
    chk("rst_ready_start", 128'(flags.ready_start), 128'(1));
    chk("rst_done", 128'(flags.done), 128'(0));
    chk("rst_beat_cnt", 128'(flags.beat_cnt), 128'(0));
    rst_n = 1'b1;

    // valid while idle must not be taken
    push.valid = 1'b1; push.data = 32'hDEAD_BEEF; push.strb = 4'hF;
    repeat (3) @(posedge clk);
    #1; push.valid = 1'b0;

    // full beats, no backpressure
    run_xfer(8, 32'h1, 0, 0, 0);
    chk("t1_nbeats", 128'(log_data.size()), 128'(2));
    chk("t1_beat0", 128'(log_data[0]), 128'h00000004_00000003_00000002_00000001);
    chk("t1_beat1", 128'(log_data[1]), 128'h00000008_00000007_00000006_00000005);
    chk("t1_strb0", 128'(log_strb[0]), 128'hFFFF);
    chk("t1_strb1", 128'(log_strb[1]), 128'hFFFF);
    chk("t1_push_span", 128'(t_push_last - t_push_first), 128'(7));
    chk("t1_done_lat", 128'(t_done_cyc - t_pop_cyc[1]), 128'(1));

    // tail beat
    run_xfer(6, 32'h1, 0, 0, 0);
    chk("t2_beat1", 128'(log_data[1]), 128'h00000000_00000000_00000006_00000005);
    chk("t2_strb1", 128'(log_strb[1]), 128'h00FF);
    chk("t2_beat_cnt", 128'(t_done_beats), 128'(2));

    // empty transfer
    d = done_cnt;
    run_xfer(0, 32'h0, 0, 0, 0);
    chk("t3_done_cnt", 128'(done_cnt), 128'(d + 1));
    chk("t3_done_lat", 128'(t_done_cyc - t_start_cyc), 128'(1));
    chk("t3_no_valid", 128'(t_pop_valid_cyc), 128'(0));
    @(posedge clk); #1;
    chk("t3_ready_start", 128'(flags.ready_start), 128'(1));

    // backpressure on the out register
    run_xfer(8, 32'h1, 0, 10, 0);
    chk("t4_acc_in_stall", 128'(t_stall_acc), 128'(3));
    chk("t4_wait_cycles", 128'(t_stall_wait), 128'(7));
    chk("t4_nbeats", 128'(log_data.size()), 128'(2));
    chk("t4_beat0", 128'(log_data[0]), 128'h00000004_00000003_00000002_00000001);
    chk("t4_beat1", 128'(log_data[1]), 128'h00000008_00000007_00000006_00000005);

    // random valid/ready
    d = done_cnt;
    for (int k = 0; k < 6; k++) run_xfer($urandom_range(1, 64), 32'(k) << 16, 1, 0, 0);
    chk("t5_done_per_start", 128'(done_cnt - d), 128'(6));

    // clear mid-transfer, then a clean restart
    d = done_cnt;
    run_xfer(8, 32'h100, 0, 0, 3);
    repeat (3) @(posedge clk);
    #1;
    chk("t6_no_done", 128'(done_cnt), 128'(d));
    chk("t6_pop_valid", 128'(pop.valid), 128'(0));
    run_xfer(4, 32'hA0, 0, 0, 0);
    chk("t6_nbeats", 128'(log_data.size()), 128'(1));
    chk("t6_beat0", 128'(log_data[0]), 128'h000000A3_000000A2_000000A1_000000A0);
    chk("t6_strb0", 128'(log_strb[0]), 128'hFFFF);
    chk("t6_done_cnt", 128'(done_cnt), 128'(d + 1));

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
